median_next_ctrl: RTL and testbench
===================================

# median_next_ctrl

Parametrised iterative median-selection controller for the median filter datapath. It issues a pivot, current buffer size and median position to the partitioning operators. It accepts their per-pass statistics (lower/equal/larger counts, min/max of the lower and larger partitions) and decides whether the median lies in the lower, equal or larger partition. It then either issues the next pass or reports the median, with an iteration cap, an even-size mean mode and valid/ready handshakes on both sides.

## Interface
- DATA_W, 8: pixel width.
- BUFF_SIZE, 1024: window sample count.
- SIZE_W, $clog2(BUFF_SIZE)+1: width of all sizes and positions.
- EVEN_MEAN, ~BUFF_SIZE[0]: 1 reports the mean of the two middle samples.
- MAX_ITER, DATA_W+2: pass cap.
- ITER_W, $clog2(MAX_ITER+1): iteration counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new window; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- cmd_valid / cmd_ready  out / in  1  pass-command handshake.
- cmd_pivot  out  DATA_W  pivot for the pass.
- cmd_buff_size  out  SIZE_W  samples in the active partition.
- cmd_median_pos  out  SIZE_W  0-based median index within the active partition.
- stat_valid / stat_ready  in / out  1  statistics handshake.
- lower_size, equal_size, larger_size  in  SIZE_W  partition counts.
- max_lower, min_lower, max_larger, min_larger  in  DATA_W  partition extrema.
- median_valid  out  1  one-cycle result pulse.
- median_out  out  DATA_W  result; held until the next result.
- iter_overflow  out  1  qualifies median_valid; result produced by cap, not convergence.
- iter_count  out  ITER_W  passes completed in the current window.

## Operation
- FSM states: IDLE, CMD, WAIT, CALC, UPD, DONE.
- IDLE → CMD on start. Loads pivot = 2^(DATA_W-1)-1, second = same, buff_size = BUFF_SIZE, median_pos = BUFF_SIZE/2, iter_count = 0.
- CMD drives cmd_valid=1 with registered pivot/buff_size/median_pos → WAIT on cmd_ready.
- WAIT drives stat_ready=1. On stat_valid all statistics are captured into registers → CALC.
- CALC registers the case from the captured values:
  - LOW if lower_size > median_pos.
  - EQ if lower_size+equal_size > median_pos, or if equal_size == buff_size.
  - LARG otherwise.
- UPD applies the update and increments iter_count:
  - LOW: pivot = (max_lower+min_lower)>>1; buff_size = lower_size; median_pos and second unchanged.
  - LARG: pivot = (max_larger+min_larger)>>1; buff_size = larger_size; median_pos -= lower_size+equal_size. If the new median_pos is 0, second = (equal_size==0 ? max_lower : pivot_old).
  - EQ, result selection:
    - If EVEN_MEAN and lower_size == median_pos: median = (pivot+second)>>1 when median_pos==0, else (pivot+max_lower)>>1.
    - Otherwise median = pivot.
  - EQ → DONE.
  - LOW/LARG with incremented iter_count == MAX_ITER → DONE with iter_overflow=1 and median = updated pivot.
  - LOW/LARG otherwise → CMD.
- DONE pulses median_valid for one cycle → IDLE.
- All means are computed in DATA_W+1 bits, floored, and truncated to DATA_W.
- Size arithmetic is SIZE_W unsigned. Inconsistent statistics (sum ≠ buff_size) are not checked.

## Timing
- Reset values:
  - State IDLE.
  - cmd_valid, stat_ready, median_valid, iter_overflow, busy, iter_count = 0.
  - median_out = 0.
  - cmd_pivot = 2^(DATA_W-1)-1.
  - cmd_buff_size = BUFF_SIZE.
  - cmd_median_pos = BUFF_SIZE/2.
- Latencies:
  - start → cmd_valid: 1 cycle.
  - stat accept → next cmd_valid or median_valid: 3 cycles (CALC, UPD, then CMD/DONE).
- cmd outputs are stable while cmd_valid=1 and cmd_ready=0. stat_ready is low outside WAIT.
- start while busy is ignored. rst_n asserted mid-pass returns to IDLE immediately, with no median_valid.
- iter_overflow is cleared on start.

## Structure
- Package median_pkg holds:
  - state enum;
  - case encoding LOW/EQ/LARG;
  - function mid(a,b) returning (a+b)>>1 at DATA_W+1 width.
- One natural sub-module, median_case_sel: registered classifier covering the CALC stage, including the EQ/EVEN_MEAN selection.

## Test plan
- Reset, no start: all outputs at reset values. Asserting start mid-pass has no effect.
- Default params, start → cmd 127/1024/512. Stats lower=600, equal=0, larger=424, max_lower=120, min_lower=10 (LOW) → cmd 65/600/512 three cycles after accept, iter_count=1.
- BUFF_SIZE=9, EVEN_MEAN=0 (pos 4), stats lower=3, equal=2 → median_valid, median_out=127.
- Default params, stats lower=512, equal=4, max_lower=100 → median_out=113 (EQ mean).
- Default params:
  - stats lower=500, equal=12, larger=512, min_larger=130, max_larger=250 → cmd 190/512/0, second=127;
  - then lower=0, equal=3 → median_out=158.
- MAX_ITER=3, always-LOW stats → after third accept median_valid with iter_overflow=1 and median_out=latest pivot.
- cmd_ready held low for 5 cycles → cmd outputs stable throughout.
- rst_n pulse in WAIT → IDLE, no median_valid.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and helpers for the iterative median-selection controller.
package median_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WAIT, CALC, UPD, DONE} state_t;
  typedef enum logic [1:0] {LOW, EQ, LARG} case_t;

  localparam int MID_W = 32;

  // Floored mean with one guard bit so a+b never wraps; callers truncate to DATA_W.
  function automatic logic [MID_W:0] mid(input logic [MID_W-1:0] a, input logic [MID_W-1:0] b);
    return ({1'b0, a} + {1'b0, b}) >> 1;
  endfunction
endpackage

// File: rtl/median_next_ctrl_if.sv
// Pass-command and pass-statistics handshakes between controller and partition operators.
interface median_next_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 11
);
  logic              cmd_valid, cmd_ready;
  logic [DATA_W-1:0] cmd_pivot;
  logic [SIZE_W-1:0] cmd_buff_size, cmd_median_pos;
  logic              stat_valid, stat_ready;
  logic [SIZE_W-1:0] lower_size, equal_size, larger_size;
  logic [DATA_W-1:0] max_lower, min_lower, max_larger, min_larger;

  modport master (
    output cmd_valid, cmd_pivot, cmd_buff_size, cmd_median_pos, stat_ready,
    input  cmd_ready, stat_valid, lower_size, equal_size, larger_size,
           max_lower, min_lower, max_larger, min_larger
  );
  modport slave (
    input  cmd_valid, cmd_pivot, cmd_buff_size, cmd_median_pos, stat_ready,
    output cmd_ready, stat_valid, lower_size, equal_size, larger_size,
           max_lower, min_lower, max_larger, min_larger
  );
endinterface

// File: rtl/median_case_sel.sv
// CALC stage: classifies where the median lies and precomputes the EQ-case result.
module median_case_sel
  import median_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 11,
  parameter bit EVEN_MEAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SIZE_W-1:0] lower_size,
  input  logic [SIZE_W-1:0] equal_size,
  input  logic [SIZE_W-1:0] buff_size,
  input  logic [SIZE_W-1:0] median_pos,
  input  logic [DATA_W-1:0] pivot,
  input  logic [DATA_W-1:0] second,
  input  logic [DATA_W-1:0] max_lower,
  output case_t             sel_case,
  output logic [DATA_W-1:0] eq_median
);
  logic [SIZE_W-1:0] le_size;
  case_t             case_d;
  logic [DATA_W-1:0] med_d;

  always_comb begin
    le_size = lower_size + equal_size;
    case_d  = LARG;
    if (lower_size > median_pos)                            case_d = LOW;
    else if (le_size > median_pos || equal_size == buff_size) case_d = EQ;
    // Median sits on the lower/equal boundary: average with the sample just below.
    med_d = pivot;
    if (EVEN_MEAN && lower_size == median_pos)
      med_d = (median_pos == '0) ? DATA_W'(mid(MID_W'(pivot), MID_W'(second)))
                                 : DATA_W'(mid(MID_W'(pivot), MID_W'(max_lower)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_case  <= LOW;
      eq_median <= '0;
    end else if (en) begin
      sel_case  <= case_d;
      eq_median <= med_d;
    end
  end
endmodule

// File: rtl/median_next_ctrl.sv
// Iterative median-selection controller: issues partition passes, narrows the
// active partition from returned statistics, and reports the median.
module median_next_ctrl
  import median_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUFF_SIZE = 1024,
  parameter int SIZE_W    = $clog2(BUFF_SIZE) + 1,
  parameter bit EVEN_MEAN = (BUFF_SIZE % 2) == 0,
  parameter int MAX_ITER  = DATA_W + 2,
  parameter int ITER_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  median_next_ctrl_if.master    bus,
  output logic                  median_valid,
  output logic [DATA_W-1:0]     median_out,
  output logic                  iter_overflow,
  output logic [ITER_W-1:0]     iter_count
);
  localparam logic [DATA_W-1:0] PIVOT_RST = DATA_W'((1 << (DATA_W - 1)) - 1);
  localparam logic [SIZE_W-1:0] SIZE_RST  = SIZE_W'(BUFF_SIZE);
  localparam logic [SIZE_W-1:0] POS_RST   = SIZE_W'(BUFF_SIZE / 2);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);

  state_t            state, state_d;
  logic [DATA_W-1:0] pivot_q, second_q, median_q;
  logic [SIZE_W-1:0] bsize_q, pos_q;
  logic [ITER_W-1:0] iter_q, iter_inc;
  logic              ovf_q;
  logic [SIZE_W-1:0] lower_q, equal_q, larger_q, pos_larg;
  logic [DATA_W-1:0] maxl_q, minl_q, maxg_q, ming_q, piv_low, piv_larg;
  case_t             sel_case;
  logic [DATA_W-1:0] eq_median;

  assign busy               = (state != IDLE);
  assign bus.cmd_valid      = (state == CMD);
  assign bus.stat_ready     = (state == WAIT);
  assign median_valid       = (state == DONE);
  assign bus.cmd_pivot      = pivot_q;
  assign bus.cmd_buff_size  = bsize_q;
  assign bus.cmd_median_pos = pos_q;
  assign median_out         = median_q;
  assign iter_overflow      = ovf_q;
  assign iter_count         = iter_q;

  median_case_sel #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .EVEN_MEAN(EVEN_MEAN)) u_case_sel (
    .clk(clk), .rst_n(rst_n), .en(state == CALC),
    .lower_size(lower_q), .equal_size(equal_q), .buff_size(bsize_q), .median_pos(pos_q),
    .pivot(pivot_q), .second(second_q), .max_lower(maxl_q),
    .sel_case(sel_case), .eq_median(eq_median)
  );

  always_comb begin
    piv_low  = DATA_W'(mid(MID_W'(maxl_q), MID_W'(minl_q)));
    piv_larg = DATA_W'(mid(MID_W'(maxg_q), MID_W'(ming_q)));
    pos_larg = pos_q - (lower_q + equal_q);
    iter_inc = iter_q + ITER_W'(1);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CMD;
      CMD:     if (bus.cmd_ready) state_d = WAIT;
      WAIT:    if (bus.stat_valid) state_d = CALC;
      CALC:    state_d = UPD;
      UPD:     state_d = (sel_case == EQ || iter_inc == ITER_CAP) ? DONE : CMD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pivot_q <= PIVOT_RST; second_q <= PIVOT_RST; bsize_q <= SIZE_RST; pos_q <= POS_RST;
      iter_q  <= '0; ovf_q <= 1'b0; median_q <= '0;
      lower_q <= '0; equal_q <= '0; larger_q <= '0;
      maxl_q  <= '0; minl_q  <= '0; maxg_q   <= '0; ming_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pivot_q <= PIVOT_RST; second_q <= PIVOT_RST; bsize_q <= SIZE_RST; pos_q <= POS_RST;
          iter_q  <= '0; ovf_q <= 1'b0;
        end
        WAIT: if (bus.stat_valid) begin
          lower_q <= bus.lower_size; equal_q <= bus.equal_size; larger_q <= bus.larger_size;
          maxl_q  <= bus.max_lower;  minl_q  <= bus.min_lower;
          maxg_q  <= bus.max_larger; ming_q  <= bus.min_larger;
        end
        UPD: begin
          iter_q <= iter_inc;
          case (sel_case)
            LOW: begin
              pivot_q <= piv_low;
              bsize_q <= lower_q;
              if (iter_inc == ITER_CAP) begin ovf_q <= 1'b1; median_q <= piv_low; end
            end
            LARG: begin
              pivot_q <= piv_larg;
              bsize_q <= larger_q;
              pos_q   <= pos_larg;
              // Median now at the bottom of the larger partition; remember its lower neighbour.
              if (pos_larg == '0) second_q <= (equal_q == '0) ? maxl_q : pivot_q;
              if (iter_inc == ITER_CAP) begin ovf_q <= 1'b1; median_q <= piv_larg; end
            end
            default: median_q <= eq_median;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_median_next_ctrl.sv
// Directed bench: default-size instance A and a BUFF_SIZE=9/MAX_ITER=3 instance B
// share stimulus; sel chooses which one is driven and observed.
module tb_median_next_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start = 1'b0, cmd_ready = 1'b0, stat_valid = 1'b0;
  logic [10:0] lower = '0, equal = '0, larger = '0;
  logic [7:0]  maxl = '0, minl = '0, maxg = '0, ming = '0;

  median_next_ctrl_if #(.DATA_W(8), .SIZE_W(11)) ifa ();
  median_next_ctrl_if #(.DATA_W(8), .SIZE_W(5))  ifb ();

  logic       busy_a, mv_a, ovf_a, busy_b, mv_b, ovf_b;
  logic [7:0] med_a, med_b;
  logic [3:0] it_a;
  logic [1:0] it_b;

  median_next_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .busy(busy_a), .bus(ifa),
    .median_valid(mv_a), .median_out(med_a), .iter_overflow(ovf_a), .iter_count(it_a)
  );
  median_next_ctrl #(.BUFF_SIZE(9), .EVEN_MEAN(1'b0), .MAX_ITER(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(busy_b), .bus(ifb),
    .median_valid(mv_b), .median_out(med_b), .iter_overflow(ovf_b), .iter_count(it_b)
  );

  assign ifa.cmd_ready  = cmd_ready & ~sel;
  assign ifa.stat_valid = stat_valid & ~sel;
  assign ifa.lower_size = lower;  assign ifa.equal_size = equal;  assign ifa.larger_size = larger;
  assign ifa.max_lower  = maxl;   assign ifa.min_lower  = minl;
  assign ifa.max_larger = maxg;   assign ifa.min_larger = ming;
  assign ifb.cmd_ready  = cmd_ready & sel;
  assign ifb.stat_valid = stat_valid & sel;
  assign ifb.lower_size = lower[4:0]; assign ifb.equal_size = equal[4:0];
  assign ifb.larger_size = larger[4:0];
  assign ifb.max_lower  = maxl;   assign ifb.min_lower  = minl;
  assign ifb.max_larger = maxg;   assign ifb.min_larger = ming;

  logic [31:0] o_cv, o_sr, o_busy, o_mv, o_ovf, o_piv, o_med, o_bs, o_pos, o_it;
  always_comb begin
    o_cv = 32'(ifa.cmd_valid); o_sr = 32'(ifa.stat_ready); o_busy = 32'(busy_a);
    o_mv = 32'(mv_a); o_ovf = 32'(ovf_a); o_piv = 32'(ifa.cmd_pivot); o_med = 32'(med_a);
    o_bs = 32'(ifa.cmd_buff_size); o_pos = 32'(ifa.cmd_median_pos); o_it = 32'(it_a);
    if (sel) begin
      o_cv = 32'(ifb.cmd_valid); o_sr = 32'(ifb.stat_ready); o_busy = 32'(busy_b);
      o_mv = 32'(mv_b); o_ovf = 32'(ovf_b); o_piv = 32'(ifb.cmd_pivot); o_med = 32'(med_b);
      o_bs = 32'(ifb.cmd_buff_size); o_pos = 32'(ifb.cmd_median_pos); o_it = 32'(it_b);
    end
  end

  int n_chk = 0, n_fail = 0, cur = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d expected %0d", nm, cur, act, exp);
    end
  endtask

  typedef struct {
    int sel, new_win, c_piv, c_bs, c_pos;
    int lo, eq, lg, mxl, mnl, mxg, mng;
    int done, med, ovf, it;
  } vec_t;
  vec_t tv[13];

  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int n;
    sel = v.sel[0];
    if (v.new_win != 0) begin
      start_pulse();
      chk("start_to_cmd_valid", o_cv, 1);
    end
    n = 0;
    while (o_cv != 1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("cmd_valid", o_cv, 1);
    chk("cmd_pivot", o_piv, v.c_piv);
    chk("cmd_buff_size", o_bs, v.c_bs);
    chk("cmd_median_pos", o_pos, v.c_pos);
    cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
    chk("stat_ready", o_sr, 1);
    lower = 11'(v.lo); equal = 11'(v.eq); larger = 11'(v.lg);
    maxl = 8'(v.mxl); minl = 8'(v.mnl); maxg = 8'(v.mxg); ming = 8'(v.mng);
    stat_valid = 1'b1; @(posedge clk); #1; stat_valid = 1'b0;
    chk("calc_quiet", {o_cv[0], o_mv[0], o_sr[0]}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (v.done != 0) begin
      chk("median_valid", o_mv, 1);
      chk("median_out", o_med, v.med);
      chk("iter_overflow", o_ovf, v.ovf);
    end else begin
      chk("next_cmd_valid", o_cv, 1);
      chk("no_median_valid", o_mv, 0);
      chk("iter_overflow_low", o_ovf, 0);
    end
    chk("iter_count", o_it, v.it);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // sel new  piv  bs    pos   lo   eq   lg   mxl mnl mxg mng done med ovf it
    tv[0]  = '{0, 1, 127, 1024, 512, 600, 0,   424, 120, 10, 0,   0,   0, 0,   0, 1};
    tv[1]  = '{0, 0, 65,  600,  512, 0,   600, 0,   0,   0,  0,   0,   1, 65,  0, 2};
    tv[2]  = '{0, 1, 127, 1024, 512, 512, 4,   508, 100, 0,  0,   0,   1, 113, 0, 1};
    tv[3]  = '{0, 1, 127, 1024, 512, 500, 12,  512, 0,   0,  250, 130, 0, 0,   0, 1};
    tv[4]  = '{0, 0, 190, 512,  0,   0,   3,   509, 0,   0,  0,   0,   1, 158, 0, 2};
    tv[5]  = '{0, 1, 127, 1024, 512, 512, 0,   512, 120, 5,  255, 128, 0, 0,   0, 1};
    tv[6]  = '{0, 0, 191, 512,  0,   0,   1,   511, 0,   0,  0,   0,   1, 155, 0, 2};
    tv[7]  = '{0, 1, 127, 1024, 512, 500, 12,  512, 0,   0,  255, 255, 0, 0,   0, 1};
    tv[8]  = '{0, 0, 255, 512,  0,   0,   1,   511, 0,   0,  0,   0,   1, 191, 0, 2};
    tv[9]  = '{1, 1, 127, 9,    4,   3,   2,   4,   0,   0,  0,   0,   1, 127, 0, 1};
    tv[10] = '{1, 1, 127, 9,    4,   8,   0,   1,   100, 20, 0,   0,   0, 0,   0, 1};
    tv[11] = '{1, 0, 60,  8,    4,   8,   0,   0,   50,  10, 0,   0,   0, 0,   0, 2};
    tv[12] = '{1, 0, 30,  8,    4,   8,   0,   0,   40,  0,  0,   0,   1, 20,  1, 3};

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_cmd_valid", o_cv, 0);
    chk("rst_stat_ready", o_sr, 0);
    chk("rst_median_valid", o_mv, 0);
    chk("rst_iter_overflow", o_ovf, 0);
    chk("rst_iter_count", o_it, 0);
    chk("rst_median_out", o_med, 0);
    chk("rst_cmd_pivot", o_piv, 127);
    chk("rst_cmd_buff_size", o_bs, 1024);
    chk("rst_cmd_median_pos", o_pos, 512);
    sel = 1'b1; #1;
    chk("rst_b_cmd_buff_size", o_bs, 9);
    chk("rst_b_cmd_median_pos", o_pos, 4);
    sel = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cur = i;
      run_row(tv[i]);
    end

    // Overflow flag from the capped window clears on the next start.
    cur = 100;
    sel = 1'b1;
    start_pulse();
    chk("ovf_cleared_on_start", o_ovf, 0);
    chk("iter_cleared_on_start", o_it, 0);
    chk("b_restart_pivot", o_piv, 127);

    // Command stalled by cmd_ready low must hold steady.
    cur = 101;
    sel = 1'b0;
    start_pulse();
    for (int k = 0; k < 5; k++) begin
      chk("stall_cmd_valid", o_cv, 1);
      chk("stall_pivot", o_piv, 127);
      chk("stall_buff_size", o_bs, 1024);
      chk("stall_median_pos", o_pos, 512);
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
    chk("wait_stat_ready", o_sr, 1);

    // start while busy is ignored.
    cur = 102;
    start = 1'b1; @(posedge clk); #1; @(posedge clk); #1; start = 1'b0;
    chk("busy_start_stat_ready", o_sr, 1);
    chk("busy_start_cmd_valid", o_cv, 0);
    chk("busy_start_busy", o_busy, 1);

    // Asynchronous reset in WAIT aborts the pass with no result.
    cur = 103;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", o_busy, 0);
    chk("rst_wait_stat_ready", o_sr, 0);
    chk("rst_wait_pivot", o_piv, 127);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_median_valid", o_mv, 0);
      chk("post_rst_idle", o_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
